// File: rtl/speed_sample_ctrl.sv
// Fixed-window signed edge counter publishing speed samples over a valid/ack handshake.
// Build option SPEED_SATURATE_EN: clamp the accumulator instead of wrapping.
module speed_sample_ctrl #(
    parameter int WINDOW_CYCLES = 50000,
    parameter int WIN_W         = 16,
    parameter int CNT_W         = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             enable_i,
    input  logic             edge_en_i,
    input  logic             count_dir_i,
    output logic [CNT_W-1:0] speed_o,
    output logic             speed_valid_o,
    input  logic             speed_ack_i,
    output logic             overrun_o,
    output logic             busy_o
);
    typedef enum logic [1:0] {IDLE, ARM, COUNT} state_t;

    localparam logic [WIN_W-1:0] TERM    = WIN_W'(WINDOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] ACC_MAX = {1'b0, {(CNT_W-1){1'b1}}};
    localparam logic [CNT_W-1:0] ACC_MIN = {1'b1, {(CNT_W-1){1'b0}}};

    state_t             state_q, state_d;
    logic [WIN_W-1:0]   timer_q, timer_d;
    logic [CNT_W-1:0]   accum_q, accum_d;
    logic [CNT_W-1:0]   speed_q, speed_d;
    logic               valid_q, valid_d;
    logic               overrun_q, overrun_d;
    logic [CNT_W-1:0]   acc_step;

    always_comb begin
        acc_step = accum_q;
        if (edge_en_i) begin
`ifdef SPEED_SATURATE_EN
            if (count_dir_i)
                acc_step = (accum_q == ACC_MAX) ? accum_q : accum_q + CNT_W'(1);
            else
                acc_step = (accum_q == ACC_MIN) ? accum_q : accum_q - CNT_W'(1);
`else
            acc_step = count_dir_i ? accum_q + CNT_W'(1) : accum_q - CNT_W'(1);
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        accum_d   = accum_q;
        speed_d   = speed_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (valid_q && speed_ack_i)
            valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable_i)
                    state_d = ARM;
            end
            ARM: begin
                timer_d = '0;
                accum_d = '0;
                state_d = COUNT;
            end
            COUNT: begin
                if (!enable_i) begin
                    // Partial window is dropped; a pending sample stays until acked.
                    state_d = IDLE;
                    timer_d = '0;
                    accum_d = '0;
                end else if (timer_q == TERM) begin
                    speed_d = acc_step;
                    valid_d = 1'b1;
                    timer_d = '0;
                    accum_d = '0;
                    if (valid_q && !speed_ack_i)
                        overrun_d = 1'b1;
                end else begin
                    timer_d = timer_q + WIN_W'(1);
                    accum_d = acc_step;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            accum_q   <= '0;
            speed_q   <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            accum_q   <= accum_d;
            speed_q   <= speed_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign speed_o       = speed_q;
    assign speed_valid_o = valid_q;
    assign overrun_o     = overrun_q;
    assign busy_o        = (state_q != IDLE);
endmodule

// File: tb/tb_speed_sample_ctrl.sv
// Directed bench for speed_sample_ctrl: single-window vector table plus handshake,
// overrun, abort and long-window (wrap/saturate) sequences.
module tb_speed_sample_ctrl;
    localparam int W = 16;

    logic       clk = 1'b0;
    logic       reset, enable, edge_en, count_dir, speed_ack;
    logic [7:0] speed;
    logic       speed_valid, overrun, busy;
    logic       enable2;
    logic [7:0] speed2;
    logic       valid2, ovr2, busy2;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    speed_sample_ctrl #(.WINDOW_CYCLES(W), .WIN_W(16), .CNT_W(8)) dut (
        .clk_i(clk), .reset_i(reset), .enable_i(enable), .edge_en_i(edge_en),
        .count_dir_i(count_dir), .speed_o(speed), .speed_valid_o(speed_valid),
        .speed_ack_i(speed_ack), .overrun_o(overrun), .busy_o(busy)
    );

    speed_sample_ctrl #(.WINDOW_CYCLES(200), .WIN_W(16), .CNT_W(8)) dut_long (
        .clk_i(clk), .reset_i(reset), .enable_i(enable2), .edge_en_i(1'b1),
        .count_dir_i(1'b1), .speed_o(speed2), .speed_valid_o(valid2),
        .speed_ack_i(1'b0), .overrun_o(ovr2), .busy_o(busy2)
    );

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Drive the inputs for the current cycle, then advance across one edge.
    task automatic tick(input logic e, input logic d, input logic a);
        edge_en   = e;
        count_dir = d;
        speed_ack = a;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        enable  = 1'b0;
        enable2 = 1'b0;
        tick(1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        reset = 1'b0;
        cyc   = 0;
    endtask

    // Enable is sampled at edge 0; returns in cycle 1 (ARM).
    task automatic start();
        do_reset();
        enable = 1'b1;
        tick(1'b0, 1'b1, 1'b0);
    endtask

    typedef struct {
        int         n_up;
        int         n_dn;
        logic       term_e;
        logic       term_d;
        logic [7:0] exp_speed;
    } vec_t;

    vec_t vt[5];
    logic e, d, a, seen_valid;
    int   k;
    logic [7:0] sat_exp;

    initial begin
        vt[0] = '{n_up: 5,  n_dn: 0, term_e: 1'b0, term_d: 1'b1, exp_speed: 8'h05};
        vt[1] = '{n_up: 0,  n_dn: 2, term_e: 1'b1, term_d: 1'b0, exp_speed: 8'hFD};
        vt[2] = '{n_up: 3,  n_dn: 4, term_e: 1'b1, term_d: 1'b1, exp_speed: 8'h00};
        vt[3] = '{n_up: 15, n_dn: 0, term_e: 1'b1, term_d: 1'b1, exp_speed: 8'h10};
        vt[4] = '{n_up: 0,  n_dn: 0, term_e: 1'b0, term_d: 1'b0, exp_speed: 8'h00};
`ifdef SPEED_SATURATE_EN
        sat_exp = 8'h7F;
`else
        sat_exp = 8'hC8;
`endif
        reset = 1'b1; enable = 1'b0; enable2 = 1'b0;
        edge_en = 1'b0; count_dir = 1'b1; speed_ack = 1'b0;

        do_reset();
        chk8("rst_speed", speed, 8'h00);
        chk1("rst_valid", speed_valid, 1'b0);
        chk1("rst_overrun", overrun, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_busy_long", busy2, 1'b0);

        // Single-window vectors: pulses in cycles 2..16, optional pulse in terminal cycle 17.
        for (int i = 0; i < 5; i++) begin
            start();
            chk1("tbl_busy_arm", busy, 1'b1);
            tick(1'b0, 1'b1, 1'b0);
            for (int c = 2; c <= 17; c++) begin
                k = c - 2;
                e = 1'b0; d = 1'b1;
                if (k < vt[i].n_up) begin
                    e = 1'b1; d = 1'b1;
                end else if (k < vt[i].n_up + vt[i].n_dn) begin
                    e = 1'b1; d = 1'b0;
                end
                if (c == 17) begin
                    e = vt[i].term_e; d = vt[i].term_d;
                    chk1("tbl_valid_pre", speed_valid, 1'b0);
                end
                tick(e, d, 1'b0);
            end
            chk8("tbl_speed", speed, vt[i].exp_speed);
            chk1("tbl_valid", speed_valid, 1'b1);
            chk1("tbl_overrun", overrun, 1'b0);
            chk1("tbl_busy", busy, 1'b1);
        end

        // Ack handshake: 3 down pulses (one terminal), ack in cycle 20.
        start();
        tick(1'b0, 1'b1, 1'b0);
        for (int c = 2; c <= 17; c++)
            tick((c == 3 || c == 10 || c == 17), 1'b0, 1'b0);
        chk8("ack_speed", speed, 8'hFD);
        tick(1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        chk1("ack_valid_hold", speed_valid, 1'b1);
        tick(1'b0, 1'b1, 1'b1);
        chk1("ack_valid_clr", speed_valid, 1'b0);
        chk1("ack_overrun", overrun, 1'b0);
        chk8("ack_speed_hold", speed, 8'hFD);
        tick(1'b0, 1'b1, 1'b1);
        chk1("ack_ignored", speed_valid, 1'b0);

        // Overrun: 2 then 7 up pulses with no ack, then late ack, then reset at timer 7.
        start();
        tick(1'b0, 1'b1, 1'b0);
        for (int c = 2; c <= 33; c++) begin
            if (c == 18) begin
                chk8("ovr_speed1", speed, 8'h02);
                chk1("ovr_none_yet", overrun, 1'b0);
            end
            tick((c == 5 || c == 9 || (c >= 20 && c <= 26)), 1'b1, 1'b0);
        end
        chk8("ovr_speed2", speed, 8'h07);
        chk1("ovr_valid", speed_valid, 1'b1);
        chk1("ovr_flag", overrun, 1'b1);
        tick(1'b0, 1'b1, 1'b1);
        chk1("ovr_ack_valid", speed_valid, 1'b0);
        chk1("ovr_sticky", overrun, 1'b1);
        while (cyc < 41)
            tick(1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        tick(1'b1, 1'b1, 1'b1);
        chk8("rstmid_speed", speed, 8'h00);
        chk1("rstmid_valid", speed_valid, 1'b0);
        chk1("rstmid_overrun", overrun, 1'b0);
        chk1("rstmid_busy", busy, 1'b0);
        reset = 1'b0;

        // Ack coinciding with the second terminal cycle (33).
        start();
        tick(1'b0, 1'b1, 1'b0);
        for (int c = 2; c <= 33; c++) begin
            a = (c == 33);
            if (c == 33)
                chk8("coin_speed_pre", speed, 8'h02);
            tick((c == 4 || c == 6 || (c >= 18 && c <= 21)), 1'b1, a);
        end
        chk8("coin_speed", speed, 8'h04);
        chk1("coin_valid", speed_valid, 1'b1);
        chk1("coin_overrun", overrun, 1'b0);

        // Enable dropped in cycle 9 (timer = 7): window discarded.
        start();
        tick(1'b0, 1'b1, 1'b0);
        for (int c = 2; c <= 8; c++)
            tick((c == 3 || c == 4), 1'b1, 1'b0);
        enable = 1'b0;
        tick(1'b1, 1'b1, 1'b0);
        chk1("abort_busy", busy, 1'b0);
        seen_valid = 1'b0;
        for (int c = 10; c <= 40; c++) begin
            seen_valid = seen_valid | speed_valid;
            tick(1'b1, 1'b1, 1'b0);
        end
        chk1("abort_no_valid", seen_valid, 1'b0);
        chk8("abort_speed", speed, 8'h00);

        // 200-cycle window with an up edge on every cycle.
        do_reset();
        enable2 = 1'b1;
        tick(1'b0, 1'b1, 1'b0);
        while (cyc < 201)
            tick(1'b0, 1'b1, 1'b0);
        chk1("long_valid_pre", valid2, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        chk8("long_speed", speed2, sat_exp);
        chk1("long_valid", valid2, 1'b1);
        chk1("long_overrun", ovr2, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/speed_sample_ctrl.md
# speed_sample_ctrl

Window sequencer for the quadrature speed path. It sits behind the encoder input synchronizers and consumes the edge-enable and direction signals. It accumulates signed edge counts over a fixed sample window of clock cycles. At the end of each window it publishes the count as a speed sample through a valid/ack handshake and restarts the next window with no dead cycles.

## Interface
- WINDOW_CYCLES, default 50000 — window length in clk cycles (1 ms at 50 MHz); legal range 2..2^WIN_W.
- WIN_W, default 16 — window timer width.
- CNT_W, default 8 — accumulator and speed width, two's complement.

- clk  in  1  — system clock.
- reset  in  1  — synchronous, active-high reset. Polarity and synchronicity are fixed.
- enable  in  1  — run request; level-sensitive.
- edge_en  in  1  — one-cycle pulse per qualified encoder A rising edge.
- count_dir  in  1  — direction for the edge in the same cycle: 1 = +1, 0 = −1.
- speed  out  CNT_W  — signed edge count of the last completed window.
- speed_valid  out  1  — the value on `speed` is unconsumed.
- speed_ack  in  1  — consumer accepts `speed`; only meaningful while speed_valid = 1.
- overrun  out  1  — sticky flag: a sample was overwritten before it was acked.
- busy  out  1  — high while state ≠ IDLE.

## Operation
- The state machine has three states: IDLE, ARM and COUNT.
  - IDLE → ARM when enable = 1.
  - ARM lasts one cycle: it clears the timer and the accumulator, then goes to COUNT.
  - COUNT → IDLE when enable = 0. The partial window is discarded and nothing is published.
- COUNT timer:
  - The timer increments every cycle.
  - The terminal cycle is the one with timer == WINDOW_CYCLES−1.
- COUNT accumulator:
  - If edge_en = 1, accum_next = accum ± 1 according to count_dir.
  - If edge_en = 0, accum_next = accum.
- Terminal cycle:
  - speed ← accum_next, so an edge in the terminal cycle counts in that window.
  - The accumulator ← 0 and the timer ← 0.
  - speed_valid ← 1.
  - The state stays COUNT.
- Handshake:
  - speed_valid clears on the edge after the cycle in which speed_ack = 1 and speed_valid = 1.
  - speed_ack while speed_valid = 0 is ignored.
- Overwrite:
  - If a terminal cycle occurs while speed_valid = 1 and speed_ack = 0, speed takes the new value, speed_valid stays 1 and overrun ← 1.
  - If a terminal cycle coincides with speed_ack = 1, the new value is latched, speed_valid stays 1 and overrun is unchanged.
- overrun clears only on reset.
- Reset:
  - Reset wins over all other inputs.
  - After reset: state IDLE, timer 0, accumulator 0, speed 0, speed_valid 0, overrun 0, busy 0.
  - Reset mid-window abandons the window.
- Enable dropped while speed_valid = 1: speed and speed_valid are held until acked.

## Timing
- Cycle numbering: enable is sampled high at edge 0.
  - ARM occupies cycle 1.
  - COUNT starts in cycle 2.
  - The first window covers cycles 2 .. WINDOW_CYCLES+1.
  - speed_valid is first high in cycle WINDOW_CYCLES+2.
- Subsequent samples arrive every WINDOW_CYCLES cycles exactly.
- Latency from the terminal-cycle edge to speed/speed_valid: 1 clock (registered outputs).
- busy rises one cycle after enable is sampled high and falls one cycle after enable is sampled low.
- The ack-to-valid-low latency is 1 clock.

## Configuration
- SPEED_SATURATE_EN defined:
  - The accumulator clamps at +2^(CNT_W−1)−1 and −2^(CNT_W−1).
  - Further edges in the same direction hold the clamp value.
  - An edge in the opposite direction moves off the clamp by 1.
- SPEED_SATURATE_EN undefined: the accumulator wraps modulo 2^CNT_W.
- Ports are identical in both builds.

## Test plan
Parameters for all scenarios: WINDOW_CYCLES = 16, CNT_W = 8, unless stated otherwise.
- Enable at edge 0, 5 edge_en pulses with count_dir = 1 in the first window → speed = 8'h05, speed_valid first high in cycle 18, busy = 1 from cycle 1.
- 3 down pulses, one of them in the terminal cycle → speed = 8'hFD (−3); ack in cycle 20 → speed_valid = 0 in cycle 21, overrun = 0.
- Two windows with 2 and 7 up pulses and no ack → speed = 8'h07 in cycle 34, speed_valid = 1, overrun = 1. overrun remains 1 after a later ack, until reset.
- Ack asserted in the same cycle as the second terminal cycle → speed updates, speed_valid stays 1, overrun = 0.
- WINDOW_CYCLES = 200 with edge_en = 1 and count_dir = 1 every COUNT cycle:
  - with SPEED_SATURATE_EN → speed = 8'h7F;
  - without it → speed = 8'hC8.
- Mid-window (timer = 7) abort:
  - enable dropped → busy = 0 next cycle and no speed_valid;
  - separately, reset asserted → every output reads 0 on the following cycle.
